mem_port_arbiter: RTL

Arbiter and sequencer for the single-port 1K-word data memory, shared between the fetch stage (instruction reads) and the memory stage (rmmovq/call/pushq writes, mrmovq/ret/popq reads). It owns every access to the array: it arbitrates between the two requesters, drives the array's control and address ports, returns read data with a completion pulse, flags bad addresses, and produces stall signals for pipeline control. Data-side requests win by default, with a starvation guard for fetch.

---
 rtl/pipe_mem_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared types for the data-memory port: FSM states, access owner, default
// widths and the icode values the memory stage decodes into requests.
package pipe_mem_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_WAIT, ST_RESP} mem_st_e;
  typedef enum logic {OWN_I, OWN_D} mem_own_e;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data requesters; data wins unless fetch
// has already been passed over STARVE_MAX times in a row.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic gnt_i_o,
  output logic gnt_d_o
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;

  always_comb begin
    gnt_d_o  = idle_i & d_req_i & ((starve_q < SMAX) | ~i_req_i);
    gnt_i_o  = idle_i & i_req_i & ~gnt_d_o;
    starve_d = starve_q;
    if (idle_i) begin
      if (gnt_d_o & i_req_i) begin
        if (starve_q != SMAX) starve_d = starve_q + CW'(1);
      end else if (gnt_i_o | ~i_req_i) begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer for the single-port data memory: IDLE grants, ACC drives the
// array for one cycle, WAIT covers the array's read register, RESP pulses valid.
module mem_port_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [63:0]       i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              i_stall,
  output logic              d_stall
);
  mem_st_e           state_q, state_d;
  mem_own_e          own_q, own_d;
  logic              we_q, we_d, err_q, err_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic              i_err_q, i_err_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, rd;
  logic              gnt_i, gnt_d, sel_we, sel_err;
  logic [63:0]       sel_addr;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk     (clk),
    .rst     (rst),
    .idle_i  (state_q == ST_IDLE),
    .i_req_i (i_req),
    .d_req_i (d_req),
    .gnt_i_o (gnt_i),
    .gnt_d_o (gnt_d)
  );

  // A bad address still walks the full sequence, just with the array untouched.
  assign sel_addr = gnt_d ? d_addr : i_addr;
  assign sel_we   = gnt_d & d_we;
  assign sel_err  = (|sel_addr[2:0]) | (|sel_addr[63:ADDR_W+3]);
  assign rd       = (err_q | we_q) ? '0 : mem_rdata;

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    i_err_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: if (gnt_d | gnt_i) begin
        state_d     = ST_ACC;
        own_d       = gnt_d ? OWN_D : OWN_I;
        we_d        = sel_we;
        err_d       = sel_err;
        mem_en_d    = ~sel_err;
        mem_we_d    = sel_we & ~sel_err;
        mem_addr_d  = sel_addr[ADDR_W+2:3];
        mem_wdata_d = gnt_d ? d_wdata : '0;
      end
      ST_ACC:  state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_RESP;
        if (own_q == OWN_D) begin
          d_valid_d = 1'b1;
          d_err_d   = err_q;
          d_rdata_d = rd;
        end else begin
          i_valid_d = 1'b1;
          i_err_d   = err_q;
          i_rdata_d = rd;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      own_q       <= OWN_I;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      i_err_q     <= i_err_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_stall   = i_req & ~i_valid_q;
  assign d_stall   = d_req & ~d_valid_q;
endmodule
